// File: rtl/ulpb_host_if_pkg.sv
// Shared widths and FSM encodings for the ulpb host-side layer controller.
package ulpb_host_if_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 32;

  // state    | meaning
  // T_IDLE   | buffer accepts writes, waiting for GO
  // T_REQ    | word presented, waiting for node ACK
  // T_ACKLOW | REQ dropped, waiting for ACK to fall
  // T_RESP   | all words handed off (or failed), waiting SUCC/FAIL
  // T_CLR    | RESP_ACK sent, waiting for node to clear SUCC/FAIL
  typedef enum logic [2:0] {T_IDLE, T_REQ, T_ACKLOW, T_RESP, T_CLR} tx_state_t;

  // R_IDLE | waiting for RX_REQ
  // R_HOLD | word taken, ACK held until REQ falls
  typedef enum logic {R_IDLE, R_HOLD} rx_state_t;

endpackage

// File: rtl/ulpb_host_if_fifo.sv
// Shift-register FIFO: head lives in entry 0 so the read port is a flop output.
module ulpb_host_if_fifo
  import ulpb_host_if_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_valid,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic             r_valid;
  logic             r_full;

  logic             w_pop;
  logic             w_push;
  logic [AW-1:0]    w_wr_idx;
  logic [CW-1:0]    w_count_n;

  assign w_pop     = i_pop & r_valid;
  assign w_push    = i_push & (~r_full | w_pop);
  // when popping, the new word lands one slot lower because everything shifts down
  assign w_wr_idx  = r_count[AW-1:0] - AW'(w_pop);
  assign w_count_n = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_full  <= 1'b0;
    end else begin
      if (w_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) r_mem[i] <= r_mem[i+1];
      end
      if (w_push) r_mem[w_wr_idx] <= i_din;
      r_count <= w_count_n;
      r_valid <= (w_count_n != '0);
      r_full  <= (w_count_n == CW'(DEPTH));
    end
  end

  assign o_dout  = r_mem[0];
  assign o_valid = r_valid;
  assign o_full  = r_full;

endmodule

// File: rtl/ulpb_host_if.sv
// Host-side ulpb layer controller: sends buffered messages over the TX word
// handshake and collects received words into a FIFO the host drains.
module ulpb_host_if
  import ulpb_host_if_pkg::*;
#(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  HOST_TX_WR,
  input  logic [DATA_WIDTH-1:0] HOST_TX_WDATA,
  input  logic [ADDR_WIDTH-1:0] HOST_TX_ADDR,
  input  logic                  HOST_TX_GO,
  output logic                  HOST_TX_BUSY,
  output logic                  HOST_TX_DONE,
  output logic                  HOST_TX_ERR,
  output logic                  HOST_RX_VALID,
  output logic [ADDR_WIDTH-1:0] HOST_RX_ADDR,
  output logic [DATA_WIDTH-1:0] HOST_RX_DATA,
  output logic                  HOST_RX_LAST,
  input  logic                  HOST_RX_RD,
  output logic                  HOST_RX_OVF,
  input  logic                  HOST_RX_OVF_CLR,
  output logic [ADDR_WIDTH-1:0] TX_ADDR,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_PEND,
  output logic                  TX_REQ,
  input  logic                  TX_ACK,
  input  logic                  TX_SUCC,
  input  logic                  TX_FAIL,
  output logic                  TX_RESP_ACK,
  input  logic [ADDR_WIDTH-1:0] RX_ADDR,
  input  logic [DATA_WIDTH-1:0] RX_DATA,
  input  logic                  RX_REQ,
  output logic                  RX_ACK,
  input  logic                  RX_PEND
);

  localparam int IW  = $clog2(TX_DEPTH);
  localparam int CW  = IW + 1;
  localparam int RXW = ADDR_WIDTH + DATA_WIDTH + 1;

  logic [DATA_WIDTH-1:0] r_buf [TX_DEPTH];

  tx_state_t             r_tx_state, w_tx_state;
  logic [CW-1:0]         r_cnt, w_cnt;
  logic [IW-1:0]         r_idx, w_idx;
  logic                  r_fail, w_fail;
  logic [ADDR_WIDTH-1:0] r_tx_addr, w_tx_addr;
  logic [DATA_WIDTH-1:0] r_tx_data, w_tx_data;
  logic                  r_tx_pend, w_tx_pend;
  logic                  r_tx_req, w_tx_req;
  logic                  r_resp_ack, w_resp_ack;
  logic                  r_busy, w_busy;
  logic                  r_done, w_done;
  logic                  r_err, w_err;
  logic                  w_buf_we;
  logic                  w_more;
  logic [IW-1:0]         w_idx_inc;

  assign w_idx_inc = r_idx + IW'(1);
  assign w_more    = (CW'(r_idx) + CW'(1)) < r_cnt;

  always_comb begin
    w_tx_state = r_tx_state;
    w_cnt      = r_cnt;
    w_idx      = r_idx;
    w_fail     = r_fail;
    w_tx_addr  = r_tx_addr;
    w_tx_data  = r_tx_data;
    w_tx_pend  = r_tx_pend;
    w_tx_req   = r_tx_req;
    w_resp_ack = 1'b0;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_err      = r_err;
    w_buf_we   = 1'b0;
    case (r_tx_state)
      T_IDLE: begin
        if (HOST_TX_GO && (r_cnt != '0)) begin
          w_tx_addr  = HOST_TX_ADDR;
          w_idx      = '0;
          w_fail     = 1'b0;
          w_err      = 1'b0;
          w_busy     = 1'b1;
          w_tx_data  = r_buf[0];
          w_tx_pend  = (r_cnt > CW'(1));
          w_tx_req   = 1'b1;
          w_tx_state = T_REQ;
        end else if (HOST_TX_WR && (r_cnt != CW'(TX_DEPTH))) begin
          w_buf_we = 1'b1;
          w_cnt    = r_cnt + CW'(1);
        end
      end
      T_REQ: begin
        if (TX_ACK || TX_FAIL) begin
          w_tx_req   = 1'b0;
          w_fail     = r_fail | TX_FAIL;
          w_tx_state = T_ACKLOW;
        end
      end
      T_ACKLOW: begin
        w_fail = r_fail | TX_FAIL;
        if (!TX_ACK) begin
          if (!w_fail && w_more) begin
            w_idx      = w_idx_inc;
            w_tx_data  = r_buf[w_idx_inc];
            w_tx_pend  = (CW'(r_idx) + CW'(2)) < r_cnt;
            w_tx_req   = 1'b1;
            w_tx_state = T_REQ;
          end else begin
            w_tx_state = T_RESP;
          end
        end
      end
      T_RESP: begin
        if (TX_SUCC || TX_FAIL) begin
          w_resp_ack = 1'b1;
          w_err      = TX_FAIL | r_fail;
          w_tx_state = T_CLR;
        end
      end
      T_CLR: begin
        if (!TX_SUCC && !TX_FAIL) begin
          w_done     = 1'b1;
          w_busy     = 1'b0;
          w_cnt      = '0;
          w_tx_pend  = 1'b0;
          w_tx_state = T_IDLE;
        end
      end
      default: w_tx_state = T_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_tx_state <= T_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_fail     <= 1'b0;
      r_tx_addr  <= '0;
      r_tx_data  <= '0;
      r_tx_pend  <= 1'b0;
      r_tx_req   <= 1'b0;
      r_resp_ack <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state;
      r_cnt      <= w_cnt;
      r_idx      <= w_idx;
      r_fail     <= w_fail;
      r_tx_addr  <= w_tx_addr;
      r_tx_data  <= w_tx_data;
      r_tx_pend  <= w_tx_pend;
      r_tx_req   <= w_tx_req;
      r_resp_ack <= w_resp_ack;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_err      <= w_err;
    end
  end

  // buffer contents are only meaningful below r_cnt, so no reset needed
  always_ff @(posedge CLK) begin
    if (w_buf_we) r_buf[r_cnt[IW-1:0]] <= HOST_TX_WDATA;
  end

  assign HOST_TX_BUSY = r_busy;
  assign HOST_TX_DONE = r_done;
  assign HOST_TX_ERR  = r_err;
  assign TX_ADDR      = r_tx_addr;
  assign TX_DATA      = r_tx_data;
  assign TX_PEND      = r_tx_pend;
  assign TX_REQ       = r_tx_req;
  assign TX_RESP_ACK  = r_resp_ack;

  rx_state_t        r_rx_state, w_rx_state;
  logic             r_rx_ack, w_rx_ack;
  logic             r_ovf, w_ovf;
  logic             w_ovf_set;
  logic             w_push;
  logic             w_fifo_full;
  logic             w_fifo_valid;
  logic [RXW-1:0]   w_head;

  always_comb begin
    w_rx_state = r_rx_state;
    w_rx_ack   = r_rx_ack;
    w_push     = 1'b0;
    w_ovf_set  = 1'b0;
    case (r_rx_state)
      R_IDLE: begin
        if (RX_REQ) begin
          if (!w_fifo_full) begin
            w_push     = 1'b1;
            w_rx_ack   = 1'b1;
            w_rx_state = R_HOLD;
          end else begin
            w_ovf_set = 1'b1;
          end
        end
      end
      R_HOLD: begin
        if (!RX_REQ) begin
          w_rx_ack   = 1'b0;
          w_rx_state = R_IDLE;
        end
      end
      default: w_rx_state = R_IDLE;
    endcase
    w_ovf = (r_ovf & ~HOST_RX_OVF_CLR) | w_ovf_set;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_rx_state <= R_IDLE;
      r_rx_ack   <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state;
      r_rx_ack   <= w_rx_ack;
      r_ovf      <= w_ovf;
    end
  end

  ulpb_host_if_fifo #(
    .WIDTH (RXW),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .i_push  (w_push),
    .i_din   ({RX_ADDR, RX_DATA, ~RX_PEND}),
    .i_pop   (HOST_RX_RD),
    .o_dout  (w_head),
    .o_valid (w_fifo_valid),
    .o_full  (w_fifo_full)
  );

  assign RX_ACK        = r_rx_ack;
  assign HOST_RX_OVF   = r_ovf;
  assign HOST_RX_VALID = w_fifo_valid;
  assign HOST_RX_ADDR  = w_head[RXW-1 -: ADDR_WIDTH];
  assign HOST_RX_DATA  = w_head[DATA_WIDTH:1];
  assign HOST_RX_LAST  = w_head[0];

endmodule

// File: tb/tb_ulpb_host_if.sv
// Directed bench for ulpb_host_if: the bench plays the node side of both handshakes.
module tb_ulpb_host_if;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        HOST_TX_WR = 1'b0;
  logic [31:0] HOST_TX_WDATA = '0;
  logic [7:0]  HOST_TX_ADDR = '0;
  logic        HOST_TX_GO = 1'b0;
  logic        HOST_TX_BUSY, HOST_TX_DONE, HOST_TX_ERR;
  logic        HOST_RX_VALID;
  logic [7:0]  HOST_RX_ADDR;
  logic [31:0] HOST_RX_DATA;
  logic        HOST_RX_LAST;
  logic        HOST_RX_RD = 1'b0;
  logic        HOST_RX_OVF;
  logic        HOST_RX_OVF_CLR = 1'b0;
  logic [7:0]  TX_ADDR;
  logic [31:0] TX_DATA;
  logic        TX_PEND, TX_REQ;
  logic        TX_ACK = 1'b0, TX_SUCC = 1'b0, TX_FAIL = 1'b0;
  logic        TX_RESP_ACK;
  logic [7:0]  RX_ADDR = '0;
  logic [31:0] RX_DATA = '0;
  logic        RX_REQ = 1'b0;
  logic        RX_ACK;
  logic        RX_PEND = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [89:0] all_out;
  assign all_out = {HOST_TX_BUSY, HOST_TX_DONE, HOST_TX_ERR, HOST_RX_VALID, HOST_RX_ADDR,
                    HOST_RX_DATA, HOST_RX_LAST, HOST_RX_OVF, TX_ADDR, TX_DATA, TX_PEND,
                    TX_REQ, TX_RESP_ACK, RX_ACK};

  always #5 CLK = ~CLK;

  ulpb_host_if #(.TX_DEPTH(4), .RX_DEPTH(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .HOST_TX_WR(HOST_TX_WR), .HOST_TX_WDATA(HOST_TX_WDATA), .HOST_TX_ADDR(HOST_TX_ADDR),
    .HOST_TX_GO(HOST_TX_GO), .HOST_TX_BUSY(HOST_TX_BUSY), .HOST_TX_DONE(HOST_TX_DONE),
    .HOST_TX_ERR(HOST_TX_ERR), .HOST_RX_VALID(HOST_RX_VALID), .HOST_RX_ADDR(HOST_RX_ADDR),
    .HOST_RX_DATA(HOST_RX_DATA), .HOST_RX_LAST(HOST_RX_LAST), .HOST_RX_RD(HOST_RX_RD),
    .HOST_RX_OVF(HOST_RX_OVF), .HOST_RX_OVF_CLR(HOST_RX_OVF_CLR),
    .TX_ADDR(TX_ADDR), .TX_DATA(TX_DATA), .TX_PEND(TX_PEND), .TX_REQ(TX_REQ),
    .TX_ACK(TX_ACK), .TX_SUCC(TX_SUCC), .TX_FAIL(TX_FAIL), .TX_RESP_ACK(TX_RESP_ACK),
    .RX_ADDR(RX_ADDR), .RX_DATA(RX_DATA), .RX_REQ(RX_REQ), .RX_ACK(RX_ACK),
    .RX_PEND(RX_PEND)
  );

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [31:0] d);
    HOST_TX_WR = 1'b1;
    HOST_TX_WDATA = d;
    cyc();
    HOST_TX_WR = 1'b0;
  endtask

  task automatic go(input logic [7:0] a);
    HOST_TX_ADDR = a;
    HOST_TX_GO = 1'b1;
    cyc();
    HOST_TX_GO = 1'b0;
  endtask

  // Node accepts the presented word; returns what it saw and REQ after ACK.
  task automatic send_word(output logic [41:0] o_word, output logic o_req_acked);
    o_word = {TX_REQ, TX_PEND, TX_ADDR, TX_DATA};
    TX_ACK = 1'b1;
    cyc();
    o_req_acked = TX_REQ;
    TX_ACK = 1'b0;
    cyc();
  endtask

  // Node reports result, holds it until it sees RESP_ACK, then clears.
  // obs = {ack_first, ack_second, done_early, done, err, busy, done_after}
  task automatic respond(input logic fail, output logic [6:0] obs);
    if (fail) TX_FAIL = 1'b1; else TX_SUCC = 1'b1;
    cyc();
    obs[6] = TX_RESP_ACK;
    cyc();
    obs[5] = TX_RESP_ACK;
    obs[4] = HOST_TX_DONE;
    TX_SUCC = 1'b0;
    TX_FAIL = 1'b0;
    cyc();
    obs[3] = HOST_TX_DONE;
    obs[2] = HOST_TX_ERR;
    obs[1] = HOST_TX_BUSY;
    cyc();
    obs[0] = HOST_TX_DONE;
  endtask

  // Node offers one word, holds REQ for two cycles, then drops it. Returns RX_ACK history.
  task automatic rx_word(input logic [7:0] a, input logic [31:0] d, input logic pend,
                         output logic [2:0] hist);
    RX_ADDR = a;
    RX_DATA = d;
    RX_PEND = pend;
    RX_REQ = 1'b1;
    cyc();
    hist[2] = RX_ACK;
    cyc();
    hist[1] = RX_ACK;
    RX_REQ = 1'b0;
    cyc();
    hist[0] = RX_ACK;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", all_out);
    end
    cyc();
    cyc();
    RESET = 1'b1;
    cyc();
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL post_reset_idle got %h want 0", all_out);
    end
  endtask

  task automatic test_single();
    logic [41:0] w;
    logic        r;
    logic [6:0]  obs;
    wr(32'hDEADBEEF);
    go(8'h12);
    checks++;
    if (HOST_TX_BUSY !== 1'b1) begin
      errors++;
      $display("FAIL single_busy got %b want 1", HOST_TX_BUSY);
    end
    send_word(w, r);
    checks++;
    if (w !== {1'b1, 1'b0, 8'h12, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL single_word got %h want %h", w, {1'b1, 1'b0, 8'h12, 32'hDEADBEEF});
    end
    checks++;
    if (r !== 1'b0 || TX_REQ !== 1'b0) begin
      errors++;
      $display("FAIL single_req_drop got %b/%b want 0/0", r, TX_REQ);
    end
    respond(1'b0, obs);
    checks++;
    if (obs !== 7'b1001000) begin
      errors++;
      $display("FAIL single_resp got %b want 1001000", obs);
    end
  endtask

  task automatic test_multi();
    logic [41:0] w;
    logic        r;
    logic [6:0]  obs;
    logic [31:0] d;
    wr(32'hA1);
    wr(32'hA2);
    wr(32'hA3);
    go(8'h56);
    for (int i = 0; i < 3; i++) begin
      d = 32'hA1 + 32'(i);
      send_word(w, r);
      checks++;
      if (w !== {1'b1, (i < 2), 8'h56, d}) begin
        errors++;
        $display("FAIL multi_word%0d got %h want %h", i, w, {1'b1, (i < 2), 8'h56, d});
      end
      checks++;
      if (r !== 1'b0) begin
        errors++;
        $display("FAIL multi_req_drop%0d got %b want 0", i, r);
      end
    end
    checks++;
    if (TX_REQ !== 1'b0) begin
      errors++;
      $display("FAIL multi_extra_req got %b want 0", TX_REQ);
    end
    respond(1'b0, obs);
    checks++;
    if (obs !== 7'b1001000) begin
      errors++;
      $display("FAIL multi_resp got %b want 1001000", obs);
    end
  endtask

  task automatic test_tx_full();
    logic [41:0] w;
    logic        r;
    logic [6:0]  obs;
    logic [31:0] d;
    for (int i = 0; i < 5; i++) wr(32'hB0 + 32'(i));
    go(8'h9A);
    for (int i = 0; i < 4; i++) begin
      d = 32'hB0 + 32'(i);
      send_word(w, r);
      checks++;
      if (w !== {1'b1, (i < 3), 8'h9A, d}) begin
        errors++;
        $display("FAIL full_word%0d got %h want %h", i, w, {1'b1, (i < 3), 8'h9A, d});
      end
    end
    checks++;
    if (TX_REQ !== 1'b0) begin
      errors++;
      $display("FAIL full_fifth_word got req %b want 0", TX_REQ);
    end
    respond(1'b0, obs);
    checks++;
    if (obs !== 7'b1001000) begin
      errors++;
      $display("FAIL full_resp got %b want 1001000", obs);
    end
  endtask

  task automatic test_fail();
    logic [41:0] w;
    logic        r;
    logic [6:0]  obs;
    wr(32'hC1);
    wr(32'hC2);
    wr(32'hC3);
    go(8'h21);
    checks++;
    if ({TX_REQ, TX_PEND, TX_DATA} !== {1'b1, 1'b1, 32'hC1}) begin
      errors++;
      $display("FAIL fail_first_word got %b %b %h want 1 1 c1", TX_REQ, TX_PEND, TX_DATA);
    end
    TX_ACK = 1'b1;
    cyc();
    TX_ACK = 1'b0;
    TX_FAIL = 1'b1;
    cyc();
    checks++;
    if (TX_REQ !== 1'b0) begin
      errors++;
      $display("FAIL fail_no_more_req got %b want 0", TX_REQ);
    end
    respond(1'b1, obs);
    checks++;
    if (obs !== 7'b1001100) begin
      errors++;
      $display("FAIL fail_resp got %b want 1001100", obs);
    end
    go(8'h21);
    checks++;
    if ({HOST_TX_BUSY, TX_REQ} !== 2'b00) begin
      errors++;
      $display("FAIL fail_buf_empty got busy %b req %b want 0 0", HOST_TX_BUSY, TX_REQ);
    end
    wr(32'hC4);
    go(8'h22);
    send_word(w, r);
    checks++;
    if (w !== {1'b1, 1'b0, 8'h22, 32'hC4}) begin
      errors++;
      $display("FAIL fail_next_msg got %h want %h", w, {1'b1, 1'b0, 8'h22, 32'hC4});
    end
    respond(1'b0, obs);
    checks++;
    if (obs !== 7'b1001000) begin
      errors++;
      $display("FAIL fail_next_resp got %b want 1001000", obs);
    end
  endtask

  task automatic test_rx();
    logic [2:0] h;
    rx_word(8'h34, 32'h11, 1'b1, h);
    checks++;
    if (h !== 3'b110) begin
      errors++;
      $display("FAIL rx_ack_w0 got %b want 110", h);
    end
    rx_word(8'h34, 32'h22, 1'b0, h);
    checks++;
    if (h !== 3'b110) begin
      errors++;
      $display("FAIL rx_ack_w1 got %b want 110", h);
    end
    checks++;
    if ({HOST_RX_VALID, HOST_RX_ADDR, HOST_RX_DATA, HOST_RX_LAST} !== {1'b1, 8'h34, 32'h11, 1'b0}) begin
      errors++;
      $display("FAIL rx_head0 got %b %h %h %b want 1 34 11 0",
               HOST_RX_VALID, HOST_RX_ADDR, HOST_RX_DATA, HOST_RX_LAST);
    end
    HOST_RX_RD = 1'b1;
    cyc();
    checks++;
    if ({HOST_RX_VALID, HOST_RX_ADDR, HOST_RX_DATA, HOST_RX_LAST} !== {1'b1, 8'h34, 32'h22, 1'b1}) begin
      errors++;
      $display("FAIL rx_head1 got %b %h %h %b want 1 34 22 1",
               HOST_RX_VALID, HOST_RX_ADDR, HOST_RX_DATA, HOST_RX_LAST);
    end
    cyc();
    HOST_RX_RD = 1'b0;
    checks++;
    if (HOST_RX_VALID !== 1'b0) begin
      errors++;
      $display("FAIL rx_drained got valid %b want 0", HOST_RX_VALID);
    end
  endtask

  task automatic test_overflow();
    logic [2:0] h;
    for (int i = 0; i < 4; i++) begin
      rx_word(8'h40, 32'h100 + 32'(i), (i != 3), h);
      checks++;
      if (h !== 3'b110) begin
        errors++;
        $display("FAIL ovf_fill%0d got %b want 110", i, h);
      end
    end
    checks++;
    if (HOST_RX_OVF !== 1'b0) begin
      errors++;
      $display("FAIL ovf_early got %b want 0", HOST_RX_OVF);
    end
    rx_word(8'h40, 32'h1EE, 1'b0, h);
    checks++;
    if ({h, HOST_RX_OVF} !== 4'b0001) begin
      errors++;
      $display("FAIL ovf_refuse got ack %b ovf %b want 000 1", h, HOST_RX_OVF);
    end
    RX_REQ = 1'b1;
    HOST_RX_OVF_CLR = 1'b1;
    cyc();
    checks++;
    if (HOST_RX_OVF !== 1'b1) begin
      errors++;
      $display("FAIL ovf_clr_vs_set got %b want 1", HOST_RX_OVF);
    end
    RX_REQ = 1'b0;
    cyc();
    HOST_RX_OVF_CLR = 1'b0;
    checks++;
    if (HOST_RX_OVF !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr got %b want 0", HOST_RX_OVF);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({HOST_RX_VALID, HOST_RX_DATA, HOST_RX_LAST} !== {1'b1, 32'h100 + 32'(i), (i == 3)}) begin
        errors++;
        $display("FAIL ovf_pop%0d got %b %h %b want 1 %h %b",
                 i, HOST_RX_VALID, HOST_RX_DATA, HOST_RX_LAST, 32'h100 + 32'(i), (i == 3));
      end
      HOST_RX_RD = 1'b1;
      cyc();
      HOST_RX_RD = 1'b0;
    end
    checks++;
    if (HOST_RX_VALID !== 1'b0) begin
      errors++;
      $display("FAIL ovf_empty got valid %b want 0", HOST_RX_VALID);
    end
    rx_word(8'h41, 32'h1FF, 1'b0, h);
    checks++;
    if ({h, HOST_RX_ADDR, HOST_RX_DATA} !== {3'b110, 8'h41, 32'h1FF}) begin
      errors++;
      $display("FAIL ovf_resume got %b %h %h want 110 41 1ff", h, HOST_RX_ADDR, HOST_RX_DATA);
    end
    HOST_RX_RD = 1'b1;
    cyc();
    HOST_RX_RD = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [41:0] w;
    logic        r;
    logic [6:0]  obs;
    logic        seen_done;
    wr(32'hD1);
    wr(32'hD2);
    go(8'h66);
    TX_ACK = 1'b1;
    cyc();
    checks++;
    if ({TX_REQ, HOST_TX_BUSY} !== 2'b01) begin
      errors++;
      $display("FAIL mid_acklow got req %b busy %b want 0 1", TX_REQ, HOST_TX_BUSY);
    end
    #2;
    RESET = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs got %h want 0", all_out);
    end
    TX_ACK = 1'b0;
    cyc();
    RESET = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      seen_done = seen_done | HOST_TX_DONE;
    end
    checks++;
    if ({seen_done, HOST_TX_BUSY} !== 2'b00) begin
      errors++;
      $display("FAIL mid_no_done got done %b busy %b want 0 0", seen_done, HOST_TX_BUSY);
    end
    wr(32'h5A5A5A5A);
    go(8'h77);
    send_word(w, r);
    checks++;
    if (w !== {1'b1, 1'b0, 8'h77, 32'h5A5A5A5A}) begin
      errors++;
      $display("FAIL mid_restart_word got %h want %h", w, {1'b1, 1'b0, 8'h77, 32'h5A5A5A5A});
    end
    respond(1'b0, obs);
    checks++;
    if (obs !== 7'b1001000) begin
      errors++;
      $display("FAIL mid_restart_resp got %b want 1001000", obs);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_tx_full();
    test_fail();
    test_rx();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
